// File: rtl/multu_unit.sv
// multu_unit
//   Sequential unsigned shift-and-add multiplier that sits beside the ALU and
//   executes MULTU. It takes WIDTH cycles per operation and writes the full
//   2*WIDTH-bit product into HI:LO.
//
//   Ports
//     clk     clock, rising edge
//     Reset   asynchronous active-high reset
//     Signal  6-bit ALU function code; only MULTU starts an operation
//     start   request strobe, sampled on the clock edge
//     dataA   multiplicand (unsigned)
//     dataB   multiplier (unsigned)
//     busy    high while a multiply is in progress
//     done    one-cycle pulse marking the HI/LO update
//     HI, LO  upper/lower halves of the last completed product
module multu_unit #(
    parameter int          WIDTH = 32,
    parameter logic [5:0]  MULTU = 6'b011001
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [5:0]       Signal,
    input  logic             start,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH:0]     sum;

    // One shift-and-add step. The adder is one bit wider than the operands so
    // the carry lands in the top bit of prod after the right shift.
    always_comb begin
        sum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_nxt = {sum, prod[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            count <= '0;
            mcand <= '0;
            prod  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && Signal == MULTU) begin
                        mcand <= dataA;
                        prod  <= {{WIDTH{1'b0}}, dataB};
                        count <= '0;
                        busy  <= 1'b1;
                        state <= MUL;
                    end
                end
                MUL: begin
                    prod  <= prod_nxt;
                    count <= count + CW'(1);
                    // Final step: publish the shifted result straight to HI/LO.
                    if (count == LAST) begin
                        HI    <= prod_nxt[2*WIDTH-1:WIDTH];
                        LO    <= prod_nxt[WIDTH-1:0];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
